mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Sequences the data-memory access of the instruction in the MEM stage, driven by the EX/MEM stage outputs (ALU_M address, rs2_data_M, funct3_M, d_re_M, d_we_M).
- Talks to a data memory/cache over a valid/ready request channel and a valid-only response channel.
- Asserts a pipeline stall while an access is outstanding.
- Generates the byte write mask, and aligns and sign-extends load data for writeback.

Parameters:
- ADDR_WIDTH, 32: byte address width; memory word address is ADDR_WIDTH-2 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- d_re_M  in  1  load in MEM stage
- d_we_M  in  1  store in MEM stage
- addr_M  in  ADDR_WIDTH  byte address (ALU_M)
- wdata_M  in  32  store data (rs2_data_M)
- funct3_M  in  3  access size/sign (RV32I encoding)
- stall  out  1  hold the pipeline
- load_data_M  out  32  aligned, extended load result
- misaligned  out  1  one-cycle pulse: access dropped
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  1=write, 0=read
- mem_req_addr  out  ADDR_WIDTH-2  word address
- mem_req_data  out  32  lane-replicated write data
- mem_req_wmask  out  4  byte enables (0 for reads)
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  32  read word

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset state and outputs: reset enters IDLE. Every output resets to 0, including load_data_M and all mem_req_* signals.
- States: IDLE, REQ, RESP, DONE.
- Access priority: access = d_re_M | d_we_M. If both are set, the store wins.
- Write mask and data:
  - SB (f3=000): wmask = 0001<<addr[1:0]; data = {4{wdata[7:0]}}.
  - SH (f3=001): wmask = 0011<<{addr[1],1'b0}; data = {2{wdata[15:0]}}.
  - SW (f3=010): wmask = 1111; data = wdata.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - The access is dropped: no request is issued and stall=0.
  - misaligned pulses for 1 cycle and the FSM stays in IDLE.
- IDLE, aligned access present:
  - stall=1 and mem_req_valid=1 in the same cycle; request fields are driven combinationally from the inputs.
  - rw, addr, data, wmask, funct3 and addr[1:0] are latched on entry.
  - If mem_req_ready: load goes to RESP, store goes to DONE. Otherwise go to REQ.
- REQ:
  - mem_req_valid=1 and stall=1; request fields come from the latched copy and stay stable until accepted.
  - On ready: load goes to RESP, store goes to DONE.
- RESP:
  - stall=1, mem_req_valid=0.
  - On mem_resp_valid: shift mem_resp_data right by 8*addr[1:0], extend, register into load_data_M, then go to DONE.
  - Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- DONE:
  - stall=0 for exactly one cycle so the pipeline advances; load_data_M is valid this cycle. Next state IDLE.
  - load_data_M holds its value until the next load response.
- Latency: best case is a store in 2 cycles (IDLE accept, DONE) and a load in 3 cycles when the response arrives the cycle after acceptance.
- No access: stall=0 in IDLE and no request is issued.
- Back-to-back accesses: a new access seen in IDLE the cycle after DONE starts immediately.
- mem_resp_valid outside RESP is ignored.
- Reset mid-operation returns to IDLE with all outputs 0. Any in-flight response is then dropped.

Optional Feature:
- Macro: MEM_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_accesses[31:0].
  - perf_stall_cycles increments every cycle stall=1.
  - perf_accesses increments on each request handshake (valid & ready).
  - Both reset to 0 on rst and wrap modulo 2^32.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- SB, addr=0x1002, wdata=0x000000AB, ready=1:
  - req wmask=0100, data=0xABABABAB, addr=0x400, rw=1.
  - stall high 1 cycle, then DONE.
- LH, addr=0x2002, ready=1, resp one cycle later with 0x8001FFFF: load_data_M=0xFFFF8001, stall high exactly 2 cycles.
- LBU, addr=0x3003, ready low for 3 cycles:
  - req_valid held 4 cycles with stable addr=0xC00.
  - resp 0x7F000000 gives load_data_M=0x0000007F.
- LW, addr=0x0006: misaligned pulses 1 cycle, no req_valid, stall=0, FSM stays IDLE.
- d_re_M=d_we_M=1, SW: write request issued (rw=1, wmask=1111).
- rst asserted during RESP: next cycle IDLE, all outputs 0; a later mem_resp_valid is ignored.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage load/store sequencer; optional perf counters via MEM_CTRL_PERF_EN
module mem_stage_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_re_M,
    input  logic                  d_we_M,
    input  logic [ADDR_WIDTH-1:0] addr_M,
    input  logic [31:0]           wdata_M,
    input  logic [2:0]            funct3_M,
    output logic                  stall,
    output logic [31:0]           load_data_M,
    output logic                  misaligned,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-3:0] mem_req_addr,
    output logic [31:0]           mem_req_data,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_data
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_accesses
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state_q, state_d;
    logic                  rw_q;
    logic [ADDR_WIDTH-3:0] addr_q;
    logic [31:0]           data_q, load_q, load_d, shifted, ext;
    logic [3:0]            wmask_q, wmask_in;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic                  access, mis, start;
    logic [31:0]           wdata_in;
    assign access   = d_re_M | d_we_M;
    assign mis      = (funct3_M[1:0] == 2'b01 & addr_M[0]) | (funct3_M[1] & |addr_M[1:0]);
    assign start    = state_q == IDLE & access & ~mis;
    assign wmask_in = funct3_M[1] ? 4'b1111 : funct3_M[0] ? 4'b0011 << {addr_M[1], 1'b0} : 4'b0001 << addr_M[1:0];
    assign wdata_in = funct3_M[1] ? wdata_M : funct3_M[0] ? {2{wdata_M[15:0]}} : {4{wdata_M[7:0]}};
    assign shifted  = mem_resp_data >> {off_q, 3'b000};
    assign ext      = f3_q[1] ? shifted :
                      f3_q[0] ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} :
                                {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
    assign load_data_M = load_q;
    // Next-state and outputs; everything is forced low while rst is held
    always_comb begin
        state_d       = state_q;
        load_d        = load_q;
        stall         = 1'b0;
        misaligned    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        mem_req_wmask = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    misaligned = access & mis;
                    if (start) begin
                        stall         = 1'b1;
                        mem_req_valid = 1'b1;
                        mem_req_rw    = d_we_M;
                        mem_req_addr  = addr_M[ADDR_WIDTH-1:2];
                        mem_req_data  = wdata_in;
                        mem_req_wmask = d_we_M ? wmask_in : 4'b0000;
                        state_d       = mem_req_ready ? (d_we_M ? DONE : RESP) : REQ;
                    end
                end
                REQ: begin
                    stall         = 1'b1;
                    mem_req_valid = 1'b1;
                    mem_req_rw    = rw_q;
                    mem_req_addr  = addr_q;
                    mem_req_data  = data_q;
                    mem_req_wmask = wmask_q;
                    state_d       = mem_req_ready ? (rw_q ? DONE : RESP) : REQ;
                end
                RESP: begin
                    stall   = 1'b1;
                    load_d  = mem_resp_valid ? ext : load_q;
                    state_d = mem_resp_valid ? DONE : RESP;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // State, load result and request latch captured when an access starts
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            load_q  <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wmask_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            if (start) begin
                rw_q    <= d_we_M;
                addr_q  <= addr_M[ADDR_WIDTH-1:2];
                data_q  <= wdata_in;
                wmask_q <= d_we_M ? wmask_in : 4'b0000;
                f3_q    <= funct3_M;
                off_q   <= addr_M[1:0];
            end
        end
    end
`ifdef MEM_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, acc_cnt_q;
    assign perf_stall_cycles = stall_cnt_q;
    assign perf_accesses     = acc_cnt_q;
    // Free-running wrap-around counters of stalled cycles and request handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            acc_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stall};
            acc_cnt_q   <= acc_cnt_q + {31'd0, mem_req_valid & mem_req_ready};
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl with a random memory responder
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst, d_re_M, d_we_M, stall, misaligned;
    logic [31:0] addr_M, wdata_M, load_data_M, mem_req_data, mem_resp_data;
    logic [2:0]  funct3_M;
    logic        mem_req_valid, mem_req_ready, mem_req_rw, mem_resp_valid;
    logic [29:0] mem_req_addr;
    logic [3:0]  mem_req_wmask;
`ifdef MEM_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_accesses;
`endif

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .d_re_M(d_re_M), .d_we_M(d_we_M), .addr_M(addr_M),
        .wdata_M(wdata_M), .funct3_M(funct3_M), .stall(stall), .load_data_M(load_data_M),
        .misaligned(misaligned), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef MEM_CTRL_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_accesses(perf_accesses)
`endif
    );

    typedef struct {logic rw; logic [29:0] addr; logic [31:0] data; logic [3:0] wmask;} req_t;
    typedef struct {bit mis; logic [31:0] ld; int stalls;} cmp_t;
    req_t        req_q[$];
    cmp_t        cmp_q[$];
    logic [31:0] word_q[$];
    int          errors = 0, checks = 0;
    logic [31:0] last_ld = 0;
    bit          rdy_fast = 1, resp_block = 0, inj = 0;
    int          hold = 0;
    logic [31:0] inj_data = 0;
    int          hs_cnt = 0, st_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: issue one instruction, queue its expected request and completion
    task automatic access(input bit re, input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rword, input int exp_stall);
        int size, off, n;
        req_t r;
        logic [31:0] v;
        size = f3[1] ? 4 : (f3[0] ? 2 : 1);
        off  = int'(a % 4);
        if ((a % size) != 0) cmp_q.push_back('{1'b1, last_ld, 0});
        else begin
            r.rw    = we;
            r.addr  = a[31:2];
            r.wmask = we ? 4'(((1 << size) - 1) << off) : 4'b0;
            for (int i = 0; i < 4; i++) r.data[8*i +: 8] = wd[8*(i % size) +: 8];
            req_q.push_back(r);
            if (re && !we) begin
                v = rword >> (8 * off);
                if (size == 1) v = (!f3[2] && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'hFF);
                else if (size == 2) v = (!f3[2] && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
                last_ld = v;
                word_q.push_back(rword);
            end
            cmp_q.push_back('{1'b0, last_ld, exp_stall});
        end
        d_re_M = re; d_we_M = we; funct3_M = f3; addr_M = a; wdata_M = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 60);
        checks++;
        if (stall) begin
            errors++;
            $display("FAIL timeout: stall still %b after %0d cycles", stall, n);
        end
        @(posedge clk); #2;
        d_re_M = 0; d_we_M = 0;
    endtask

    // Memory model: random ready, delayed responses, stray responses outside a load
    bit pending = 0;
    int dly = 0;
    initial begin
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_valid && mem_req_ready && !mem_req_rw && !resp_block) begin
                pending = 1;
                dly = rdy_fast ? 0 : int'($urandom_range(0, 3));
            end
            if (mem_req_valid && !mem_req_ready && hold > 0) hold--;
            @(posedge clk); #1;
            if (inj) begin
                mem_resp_valid = 1; mem_resp_data = inj_data;
            end else if (pending && dly == 0) begin
                mem_resp_valid = 1;
                mem_resp_data = word_q.size() ? word_q.pop_front() : 32'h0;
                pending = 0;
            end else begin
                if (pending) dly--;
                mem_resp_valid = !pending && !rdy_fast && ($urandom % 4 == 0);
                mem_resp_data = $urandom;
            end
            mem_req_ready = hold > 0 ? 1'b0 : rdy_fast ? 1'b1 : ($urandom % 3 != 0);
        end
    end

    // Monitor: checks every presented request and every completion against the queues
    bit   prev_stall = 0;
    int   scnt = 0;
    req_t r;
    cmp_t c;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0; scnt = 0; hs_cnt = 0; st_cnt = 0;
        end else begin
            if (stall) st_cnt++;
            if (mem_req_valid) begin
                if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                else begin
                    r = req_q[0];
                    chk("req_rw", 32'(mem_req_rw), 32'(r.rw));
                    chk("req_addr", 32'(mem_req_addr), 32'(r.addr));
                    chk("req_wmask", 32'(mem_req_wmask), 32'(r.wmask));
                    if (r.rw) chk("req_data", mem_req_data, r.data);
                    if (mem_req_ready) begin
                        void'(req_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
            if (misaligned) begin
                if (cmp_q.size() == 0) chk("unexpected_misaligned", 32'd1, 32'd0);
                else begin
                    c = cmp_q.pop_front();
                    chk("misaligned_expected", 32'(c.mis), 32'd1);
                    chk("misaligned_stall", 32'(stall), 32'd0);
                    chk("misaligned_valid", 32'(mem_req_valid), 32'd0);
                end
            end
            if (stall) scnt++;
            if (prev_stall && !stall) begin
                if (cmp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    c = cmp_q.pop_front();
                    chk("done_not_misaligned", 32'(c.mis), 32'd0);
                    chk("load_data", load_data_M, c.ld);
                    if (c.stalls >= 0) chk("stall_cycles", 32'(scnt), 32'(c.stalls));
                end
                scnt = 0;
            end
            prev_stall = stall;
        end
    end

    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    initial begin
        int k;
        rst = 1; d_re_M = 0; d_we_M = 0; addr_M = 0; wdata_M = 0; funct3_M = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_valid", 32'(mem_req_valid), 0);
        chk("rst_load", load_data_M, 0);
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 0);
        chk("idle_valid", 32'(mem_req_valid), 0);
        chk("idle_misaligned", 32'(misaligned), 0);
        @(posedge clk); #2;
        access(0, 1, 3'b000, 32'h1002, 32'h000000AB, 0, 1);
        access(1, 0, 3'b001, 32'h2002, 0, 32'h8001FFFF, 2);
        hold = 3;
        @(posedge clk); #2;
        access(1, 0, 3'b100, 32'h3003, 0, 32'h7F000000, 5);
        access(1, 0, 3'b010, 32'h0006, 0, 0, 0);
        access(1, 1, 3'b010, 32'h0010, 32'h12345678, 0, 1);
        access(1, 0, 3'b000, 32'h0021, 0, 32'h0000F000, 2);
        // Reset while waiting for a load response; the late response must be ignored
        resp_block = 1;
        req_q.push_back('{1'b0, 30'h40, 32'h0, 4'h0});
        d_re_M = 1; funct3_M = 3'b010; addr_M = 32'h100;
        @(negedge clk);
        @(posedge clk); #2 d_re_M = 0;
        @(negedge clk);
        chk("resp_stall", 32'(stall), 1);
        chk("resp_valid", 32'(mem_req_valid), 0);
        @(posedge clk); #2 rst = 1;
        @(negedge clk);
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_valid", 32'(mem_req_valid), 0);
        @(posedge clk); #2 rst = 0;
        inj = 1; inj_data = 32'hDEADBEEF;
        last_ld = 0;
        @(negedge clk);
        chk("postrst_stall", 32'(stall), 0);
        chk("postrst_valid", 32'(mem_req_valid), 0);
        chk("postrst_load", load_data_M, 0);
        chk("postrst_misaligned", 32'(misaligned), 0);
        repeat (2) begin
            @(posedge clk); #2;
            @(negedge clk);
            chk("stray_resp_stall", 32'(stall), 0);
            chk("stray_resp_load", load_data_M, 0);
        end
        @(posedge clk); #2;
        inj = 0; resp_block = 0; rdy_fast = 0;
        for (int t = 0; t < 250; t++) begin
            k = int'($urandom % 10);
            if (k == 9) begin
                @(negedge clk);
                chk("gap_stall", 32'(stall), 0);
                chk("gap_valid", 32'(mem_req_valid), 0);
                @(posedge clk); #2;
            end else if (k < 4)
                access(1, 0, lf[$urandom % 5], $urandom, $urandom, $urandom, -1);
            else
                access(k == 8, 1, 3'($urandom % 3), $urandom, $urandom, 0, -1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("req_q_empty", 32'(req_q.size()), 0);
        chk("cmp_q_empty", 32'(cmp_q.size()), 0);
`ifdef MEM_CTRL_PERF_EN
        chk("perf_accesses", perf_accesses, 32'(hs_cnt));
        chk("perf_stall_cycles", perf_stall_cycles, 32'(st_cnt));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
